// File: rtl/latch_capture_pkg.sv
// latch_capture_pkg: shared controller state encoding and phase counter sizing
// Contents:
//   state_t     - capture FSM states IDLE/OPEN/SETTLE/CAPTURE, 2-bit encoding 0..3
//   phase_width - bits needed by the phase counter for the longer timed window
package latch_capture_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // The phase counter only counts to (window length - 1), so the longer of the
    // open window and the settle window sets its width.
    function automatic int phase_width(input int open_cycles, input int sync_stages);
        int m;
        m = open_cycles > sync_stages + 1 ? open_cycles : sync_stages + 1;
        return m > 1 ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/latch_capture_fifo.sv
// latch_capture_fifo: show-ahead FIFO holding captured latch words
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (empties the FIFO)
//   push       - write request; accepted when not full or when popping the same cycle
//   wr_data    - word to write
//   pop        - read request; ignored while empty
//   rd_data    - head word, 0 when empty
//   valid      - FIFO non-empty
//   full       - occupancy equals DEPTH
//   count      - occupancy
module latch_capture_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             wr, rd;

    assign valid   = count != '0;
    assign full    = count == CW'(DEPTH);
    assign rd      = pop && valid;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr      = push && (!full || rd);
    assign rd_data = valid ? mem[rptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            count <= count + CW'(wr) - CW'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= wr_data;
    end

endmodule

// File: rtl/latch_word_capture.sv
// latch_word_capture: drives a gated-latch bank enable and captures its word into a FIFO
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - request one capture, sampled only while idle
//   busy       - capture sequence in progress
//   e          - registered latch enable
//   q_in       - asynchronous latch bank outputs
//   out_data   - FIFO head (0 when empty); out_valid - FIFO non-empty
//   out_ready  - consumer accepts head; count - FIFO occupancy
//   overflow   - sticky, a capture was dropped because the FIFO was full
// Build option: LATCH_CAPTURE_CHANGE_FILTER_EN skips pushing a word equal to the last pushed one.
module latch_word_capture
    import latch_capture_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int OPEN_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       busy,
    output logic                       e,
    input  logic [WIDTH-1:0]           q_in,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);
    localparam int PW = phase_width(OPEN_CYCLES, SYNC_STAGES);

    state_t           state, state_n;
    logic [PW-1:0]    phase, phase_n;
    logic [WIDTH-1:0] sync [SYNC_STAGES];
    logic [WIDTH-1:0] word;
    logic             push, pop, full, accepted;

    assign busy     = state != IDLE;
    assign word     = sync[SYNC_STAGES-1];
    assign pop      = out_valid && out_ready;
    assign accepted = push && (!full || pop);

    always_comb begin
        state_n = state;
        phase_n = '0;
        case (state)
            IDLE:    state_n = start ? OPEN : IDLE;
            OPEN:    if (phase == PW'(OPEN_CYCLES - 1)) state_n = SETTLE;
                     else phase_n = phase + 1'b1;
            // One extra settle cycle beyond the synchroniser depth so the word
            // sampled in CAPTURE left the latch after E had already closed.
            SETTLE:  if (phase == PW'(SYNC_STAGES)) state_n = CAPTURE;
                     else phase_n = phase + 1'b1;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            phase    <= '0;
            e        <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
        end else begin
            state    <= state_n;
            phase    <= phase_n;
            e        <= state_n == OPEN;
            overflow <= overflow || (push && full && !pop);
            sync[0]  <= q_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
        end
    end

`ifdef LATCH_CAPTURE_CHANGE_FILTER_EN
    logic [WIDTH-1:0] last_word;
    logic             last_vld;

    assign push = state == CAPTURE && !(last_vld && last_word == word);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_word <= '0;
            last_vld  <= 1'b0;
        end else if (accepted) begin
            last_word <= word;
            last_vld  <= 1'b1;
        end
    end
`else
    assign push = state == CAPTURE;
`endif

    latch_capture_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (word),
        .pop     (out_ready),
        .rd_data (out_data),
        .valid   (out_valid),
        .full    (full),
        .count   (count)
    );

endmodule

// File: tb/tb_latch_word_capture.sv
// tb_latch_word_capture: directed bench with a timeline/queue model of the capture controller
module tb_latch_word_capture;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;

    logic       clk = 1'b0;
    logic       rst_n, start, out_ready, busy, e, out_valid, overflow;
    logic [7:0] q_in, out_data;
    logic [2:0] count;

    int checks = 0;
    int fails  = 0;
    bit started = 0;

    latch_word_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .e         (e),
        .q_in      (q_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Model: a capture accepted at edge s holds E for edges s..s+1, is busy for
    // edges s..s+5 and pushes, at edge s+6, the word q_in had SYNC edges earlier.
    int         n = 0, s = 0;
    bit         act = 0, m_ovf = 0, m_lv = 0, m_busy = 0, m_e = 0, m_pop, m_skip;
    logic [7:0] m_last = 8'h0, m_word, m_head;
    logic [7:0] qh[$];
    logic [7:0] mq[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act = 0; m_ovf = 0; m_lv = 0; m_last = 8'h0;
            mq.delete(); qh.delete();
            for (int i = 0; i < 4; i++) qh.push_front(8'h0);
        end else begin
            n++;
            m_pop = mq.size() != 0 && out_ready;
            if (m_pop) void'(mq.pop_front());
            if (act && n - s == 6) begin
                act = 0;
                m_word = qh[SYNC-1];
`ifdef LATCH_CAPTURE_CHANGE_FILTER_EN
                m_skip = m_lv && m_word == m_last;
`else
                m_skip = 0;
`endif
                if (!m_skip) begin
                    if (mq.size() == DEPTH) m_ovf = 1;
                    else begin
                        mq.push_back(m_word);
                        m_last = m_word;
                        m_lv = 1;
                    end
                end
            end else if (!act && start) begin
                act = 1;
                s = n;
            end
            qh.push_front(q_in);
            void'(qh.pop_back());
        end
        m_busy = act;
        m_e    = act && n - s <= 1;
    end

    always @(negedge clk) begin
        if (started) begin
            m_head = mq.size() != 0 ? mq[0] : 8'h0;
            checks++;
            if (busy !== m_busy || e !== m_e || out_valid !== (mq.size() != 0) ||
                out_data !== m_head || count !== 3'(mq.size()) || overflow !== m_ovf) begin
                fails++;
                $display("FAIL cycle_model t=%0t busy/e/valid/data/count/ovf got=%b/%b/%b/%h/%0d/%b exp=%b/%b/%b/%h/%0d/%b",
                         $time, busy, e, out_valid, out_data, count, overflow,
                         m_busy, m_e, mq.size() != 0, m_head, mq.size(), m_ovf);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic capture(input logic [7:0] w);
        q_in = w;
        start = 1;
        tick();
        start = 0;
        repeat (6) tick();
    endtask

    task automatic do_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; start = 0; q_in = 8'h0; out_ready = 0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1;
        started = 1;
        chk("rst_count", 32'(count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_e", 32'(e), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_data", 32'(out_data), 0);

        q_in = 8'hA5; start = 1; tick(); start = 0;
        chk("t1_e_edge0", 32'(e), 1);
        chk("t1_busy_edge0", 32'(busy), 1);
        tick();
        chk("t1_e_edge1", 32'(e), 1);
        tick();
        chk("t1_e_edge2", 32'(e), 0);
        repeat (3) tick();
        chk("t1_busy_edge5", 32'(busy), 1);
        chk("t1_valid_edge5", 32'(out_valid), 0);
        tick();
        chk("t1_valid_edge6", 32'(out_valid), 1);
        chk("t1_data", 32'(out_data), 32'hA5);
        chk("t1_busy_edge6", 32'(busy), 0);
        out_ready = 1; tick(); out_ready = 0;
        chk("t1_drained", 32'(count), 0);

        q_in = 8'h11; start = 1; tick(); start = 0; q_in = 8'h22;
        for (int i = 0; i < 4; i++) begin start = 1; tick(); end
        start = 0;
        repeat (2) tick();
        chk("t2_data", 32'(out_data), 32'h22);
        repeat (4) tick();
        chk("t2_single", 32'(count), 1);
        out_ready = 1; tick(); out_ready = 0;

        for (int w = 1; w <= 5; w++) capture(8'(w));
        chk("t3_count", 32'(count), 4);
        chk("t3_ovf", 32'(overflow), 1);
        out_ready = 1;
        for (int i = 1; i <= 4; i++) begin chk("t3_order", 32'(out_data), 32'(i)); tick(); end
        out_ready = 0;
        chk("t3_empty", 32'(count), 0);

        do_reset();
        for (int w = 8'h41; w <= 8'h44; w++) capture(8'(w));
        q_in = 8'h45; start = 1; tick(); start = 0;
        repeat (5) tick();
        out_ready = 1; tick(); out_ready = 0;
        chk("t4_count", 32'(count), 4);
        chk("t4_ovf", 32'(overflow), 0);
        out_ready = 1;
        for (int i = 8'h42; i <= 8'h45; i++) begin chk("t4_order", 32'(out_data), 32'(i)); tick(); end
        out_ready = 0;

        capture(8'h77);
        q_in = 8'h66; start = 1; tick(); start = 0; tick();
        chk("t5_e_open", 32'(e), 1);
        rst_n = 0;
        #1;
        chk("t5_e_rst", 32'(e), 0);
        chk("t5_count_rst", 32'(count), 0);
        chk("t5_valid_rst", 32'(out_valid), 0);
        tick();
        rst_n = 1;
        capture(8'h5A);
        chk("t5_count", 32'(count), 1);
        chk("t5_data", 32'(out_data), 32'h5A);

        do_reset();
        capture(8'h3C); capture(8'h3C); capture(8'h3C); capture(8'h3D);
`ifdef LATCH_CAPTURE_CHANGE_FILTER_EN
        chk("t6_count", 32'(count), 2);
        chk("t6_first", 32'(out_data), 32'h3C);
        out_ready = 1; tick(); out_ready = 0;
        chk("t6_second", 32'(out_data), 32'h3D);
`else
        chk("t6_count", 32'(count), 4);
        chk("t6_first", 32'(out_data), 32'h3C);
        out_ready = 1; repeat (3) tick(); out_ready = 0;
        chk("t6_last", 32'(out_data), 32'h3D);
`endif
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
